// File: rtl/mips_cpu_pc_sequencer.sv
// Multi-cycle PC sequencing FSM: decodes the executing instruction, resolves branches,
// and drives PC select/advance with delay-slot tracking, memory stalls and halt-on-jr-zero.
module mips_cpu_pc_sequencer #(
  parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mem_waitrequest,
  output logic [1:0]  pc_ctrl,
  output logic        pc_en,
  output logic [31:0] jump_reg,
  output logic        link_en,
  output logic        in_delay_slot,
  output logic        delay_err,
  output logic        halted,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_q, state_n;
  logic        pending_halt;
  logic [1:0]  ctrl_q;
  logic [31:0] tgt_q;
  logic        link_q;
  logic        cf_q;
  logic        hit_q;

  logic [5:0]  op;
  logic [4:0]  rt_f;
  logic [5:0]  funct;
  logic        is_br, taken, is_j, is_jr, is_link;
  logic        is_cf, demote, is_mem, halt_hit;
  logic [1:0]  dec_ctrl;
  logic [31:0] dec_tgt;
  logic        dec_link;
  logic        cur_cf, cur_hit;

  assign op     = instr[31:26];
  assign rt_f   = instr[20:16];
  assign funct  = instr[5:0];
  assign state  = state_q;

  always_comb begin
    is_br   = 1'b0;
    taken   = 1'b0;
    is_j    = 1'b0;
    is_jr   = 1'b0;
    is_link = 1'b0;
    case (op)
      6'h00: begin
        if (funct == 6'h08) is_jr = 1'b1;
        if (funct == 6'h09) begin
          is_jr   = 1'b1;
          is_link = 1'b1;
        end
      end
      6'h01: begin
        case (rt_f)
          5'h00: begin is_br = 1'b1; taken = rs_data[31]; end
          5'h01: begin is_br = 1'b1; taken = ~rs_data[31]; end
          5'h10: begin is_br = 1'b1; taken = rs_data[31];  is_link = 1'b1; end
          5'h11: begin is_br = 1'b1; taken = ~rs_data[31]; is_link = 1'b1; end
          default: ;
        endcase
      end
      6'h02: is_j = 1'b1;
      6'h03: begin is_j = 1'b1; is_link = 1'b1; end
      6'h04: begin is_br = 1'b1; taken = (rs_data == rt_data); end
      6'h05: begin is_br = 1'b1; taken = (rs_data != rt_data); end
      6'h06: begin is_br = 1'b1; taken = rs_data[31] | (rs_data == 32'd0); end
      6'h07: begin is_br = 1'b1; taken = ~rs_data[31] & (rs_data != 32'd0); end
      default: ;
    endcase
  end

  // A control transfer sitting in a delay slot is neutralised and behaves like a plain instruction.
  assign is_cf    = is_br | is_j | is_jr;
  assign demote   = is_cf & in_delay_slot;
  assign is_mem   = (op >= 6'h20) && (op <= 6'h2E);
  assign halt_hit = is_jr & ~demote & (rs_data == HALT_ADDR);
  assign dec_link = is_link & ~demote;

  always_comb begin
    dec_ctrl = 2'd0;
    if (!demote) begin
      if (is_jr)               dec_ctrl = 2'd3;
      else if (is_j)           dec_ctrl = 2'd2;
      else if (is_br && taken) dec_ctrl = 2'd1;
    end
  end

  assign dec_tgt = (dec_ctrl == 2'd3) ? rs_data : 32'd0;
  assign cur_cf  = (state_q == EXEC) ? (is_cf & ~demote) : cf_q;
  assign cur_hit = (state_q == EXEC) ? halt_hit : hit_q;

  always_comb begin
    state_n  = state_q;
    pc_en    = 1'b0;
    pc_ctrl  = 2'd0;
    jump_reg = 32'd0;
    link_en  = 1'b0;
    halted   = 1'b0;
    case (state_q)
      FETCH: begin
        if (!mem_waitrequest) state_n = EXEC;
      end
      EXEC: begin
        pc_ctrl  = dec_ctrl;
        jump_reg = dec_tgt;
        link_en  = dec_link;
        if (is_mem && mem_waitrequest) begin
          state_n = STALL;
        end else begin
          pc_en   = 1'b1;
          state_n = pending_halt ? HALT : FETCH;
        end
      end
      STALL: begin
        pc_ctrl  = ctrl_q;
        jump_reg = tgt_q;
        if (!mem_waitrequest) begin
          pc_en   = 1'b1;
          link_en = link_q;
          state_n = pending_halt ? HALT : FETCH;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      pending_halt  <= 1'b0;
      ctrl_q        <= 2'd0;
      tgt_q         <= 32'd0;
      link_q        <= 1'b0;
      cf_q          <= 1'b0;
      hit_q         <= 1'b0;
      in_delay_slot <= 1'b0;
      delay_err     <= 1'b0;
    end else begin
      state_q <= state_n;
      if (state_q == EXEC) begin
        if (demote) delay_err <= 1'b1;
        if (is_mem && mem_waitrequest) begin
          ctrl_q <= dec_ctrl;
          tgt_q  <= dec_tgt;
          link_q <= dec_link;
          cf_q   <= is_cf & ~demote;
          hit_q  <= halt_hit;
        end
      end
      if (pc_en) begin
        in_delay_slot <= cur_cf;
        pending_halt  <= pending_halt | cur_hit;
      end
    end
  end

endmodule
